lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Serial-entry sequencing controller for the six-digit electronic lock. Collects one 4-bit digit per keypad strobe into a six-digit entry buffer, compares it against an internally held password, and drives unlock, reprogramming and failed-attempt lockout. Sits between the keypad/debounce front end and the lock actuator/alarm outputs, replacing parallel six-digit entry with a sequenced state machine.

## Interface
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..7)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (1..65535)
- OPEN_CYCLES, 500, unlock hold time in clk cycles (1..65535)
- clk  in  1  system clock, rising edge
- clr  in  1  reset, synchronous, active-low
- key_vld  in  1  one-cycle digit strobe
- key_digit  in  4  digit value; valid 0..9
- key_ent  in  1  one-cycle enter strobe
- key_clr  in  1  one-cycle clear/abort strobe
- prog_req  in  1  request password reprogramming (honoured only in OPEN)
- unlock  out  1  lock actuator drive
- alarm  out  1  lockout indicator
- prog_mode  out  1  high while collecting a new password
- err  out  1  one-cycle pulse on mismatch
- entry_cnt  out  3  digits held in entry buffer (0..6)
- fail_cnt  out  3  consecutive mismatch count
- state  out  3  current FSM state, for display/debug

## Operation
- States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROG=4, LOCKOUT=5.
- Reset (clr low at an edge): state IDLE, buffer and entry_cnt 0, fail_cnt 0, timer 0, password 1-2-3-4-5-6 (digit 1 first), all outputs 0. Overrides every other input, including mid-OPEN, mid-PROG and mid-LOCKOUT.
- Input priority per cycle: key_clr > key_ent > key_vld.
- Digit capture (IDLE/ENTRY/PROG): key_vld with key_digit<=9 and entry_cnt<6 stores digit at buffer[entry_cnt], entry_cnt+1. Digits >9 and a 7th digit are ignored; no state change.
- IDLE: accepted digit -> ENTRY.
- ENTRY: key_clr -> IDLE, buffer cleared. key_ent with entry_cnt==6 -> CHECK. key_ent with entry_cnt<6 -> IDLE, buffer cleared, no failure counted.
- CHECK (one cycle): all six digits equal password -> OPEN, fail_cnt=0, timer loaded OPEN_CYCLES-1. Otherwise err pulses; fail_cnt+1; if the new count equals MAX_FAIL -> LOCKOUT, timer loaded LOCK_CYCLES-1, else -> IDLE. Buffer cleared on exit either way.
- OPEN: unlock=1; timer decrements each cycle; at 0 -> IDLE. prog_req -> PROG (takes priority over timer expiry). key_clr -> IDLE immediately (manual relock). Digits ignored.
- PROG: prog_mode=1, unlock=0; digits captured as above. key_ent with entry_cnt==6 -> password overwritten with buffer, -> IDLE. key_ent with entry_cnt<6 or key_clr -> IDLE, password unchanged. No timeout.
- LOCKOUT: alarm=1; all keys and prog_req ignored; timer decrements; at 0 -> IDLE, fail_cnt=0.
- unlock, alarm, prog_mode are registered decodes of state (OPEN, LOCKOUT, PROG). err is registered.

## Timing
- Digit accepted at edge k: entry_cnt updated after edge k.
- key_ent at edge k (6 digits): state CHECK after k; OPEN or IDLE/LOCKOUT after k+1; unlock/alarm/err valid after k+1.
- unlock stays high exactly OPEN_CYCLES cycles absent key_clr/prog_req.
- alarm stays high exactly LOCK_CYCLES cycles.
- Password write takes effect after the edge sampling key_ent in PROG; next CHECK uses new value.
- Timer 16-bit, down-counting; no wrap (stops at 0 on exit).

## Configuration
- LOCKOUT_EN defined: failed-attempt counting and LOCKOUT state as above.
- LOCKOUT_EN undefined: fail_cnt held 0, LOCKOUT unreachable, mismatch always -> IDLE with err pulse, alarm tied 0; MAX_FAIL and LOCK_CYCLES unused. State encoding unchanged.

## Test plan
- Reset, enter 1,2,3,4,5,6, key_ent -> unlock high 2 edges after key_ent for 500 cycles, fail_cnt 0, then state IDLE.
- Enter 1,2,3,4,5,7, key_ent three times (LOCKOUT_EN) -> err pulse each, fail_cnt 1,2 then alarm high 1000 cycles, keys during lockout ignored, then IDLE with fail_cnt 0.
- Unlock, assert prog_req, enter 9,8,7,6,5,4, key_ent -> IDLE; 1-2-3-4-5-6 now mismatches, 9-8-7-6-5-4 unlocks.
- Digit 0xA, 7 digits, key_ent after 4 digits, key_clr with key_vld same cycle -> invalid/extra digits ignored, entry_cnt saturates at 6, short enter clears without failure, clear wins.
- Drive clr low mid-OPEN and mid-LOCKOUT -> next edge all outputs 0, password back to 1-2-3-4-5-6.
- LOCKOUT_EN undefined: five mismatches -> five err pulses, alarm never high, fail_cnt stays 0.

Source files
------------

// File: rtl/lock_sequencer.sv
// Six-digit serial-entry lock controller: digit capture, password check, timed unlock,
// reprogramming, and failed-attempt lockout when LOCKOUT_EN is defined.
module lock_sequencer #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned OPEN_CYCLES = 500
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_vld,
  input  logic [3:0] key_digit,
  input  logic       key_ent,
  input  logic       key_clr,
  input  logic       prog_req,
  output logic       unlock,
  output logic       alarm,
  output logic       prog_mode,
  output logic       err,
  output logic [2:0] entry_cnt,
  output logic [2:0] fail_cnt,
  output logic [2:0] state
);

  localparam int unsigned DIGITS = 6;
  localparam int unsigned DW     = 4;
  localparam int unsigned CW     = 3;
  localparam int unsigned TW     = 16;

  localparam logic [DIGITS-1:0][DW-1:0] PW_RESET  = 24'h654321;
  localparam logic [TW-1:0]             OPEN_LOAD = TW'(OPEN_CYCLES - 1);

  if (MAX_FAIL == 0 || MAX_FAIL > 7 || LOCK_CYCLES == 0 || LOCK_CYCLES > 65535 ||
      OPEN_CYCLES == 0 || OPEN_CYCLES > 65535) begin : g_bad_cfg
    $error("lock_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  state_e                      state_q;
  logic [DIGITS-1:0][DW-1:0]   ent_buf_q;
  logic [DIGITS-1:0][DW-1:0]   pw_q;
  logic [CW-1:0]               entry_cnt_q;
  logic [TW-1:0]               timer_q;
  logic                        unlock_q;
  logic                        prog_mode_q;
  logic                        err_q;
  logic                        digit_ok;
  logic                        code_match;

`ifdef LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  logic [CW-1:0] fail_cnt_q;
  logic          alarm_q;
  assign fail_cnt = fail_cnt_q;
  assign alarm    = alarm_q;
`else
  assign fail_cnt = '0;
  assign alarm    = 1'b0;
`endif

  // A digit is only taken when no higher-priority strobe is present this cycle.
  assign digit_ok   = key_vld && !key_clr && !key_ent && (key_digit <= 4'd9) &&
                      (entry_cnt_q < CW'(DIGITS));
  assign code_match = (ent_buf_q == pw_q);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      ent_buf_q   <= '0;
      pw_q        <= PW_RESET;
      entry_cnt_q <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      prog_mode_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt_q  <= '0;
      alarm_q     <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (digit_ok) begin
            ent_buf_q[entry_cnt_q] <= key_digit;
            entry_cnt_q            <= entry_cnt_q + CW'(1);
            state_q                <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (key_clr || (key_ent && entry_cnt_q != CW'(DIGITS))) begin
            ent_buf_q   <= '0;
            entry_cnt_q <= '0;
            state_q     <= S_IDLE;
          end else if (key_ent) begin
            state_q <= S_CHECK;
          end else if (digit_ok) begin
            ent_buf_q[entry_cnt_q] <= key_digit;
            entry_cnt_q            <= entry_cnt_q + CW'(1);
          end
        end
        S_CHECK: begin
          ent_buf_q   <= '0;
          entry_cnt_q <= '0;
          if (code_match) begin
            state_q  <= S_OPEN;
            timer_q  <= OPEN_LOAD;
            unlock_q <= 1'b1;
`ifdef LOCKOUT_EN
            fail_cnt_q <= '0;
`endif
          end else begin
            err_q <= 1'b1;
`ifdef LOCKOUT_EN
            fail_cnt_q <= fail_cnt_q + CW'(1);
            if (fail_cnt_q + CW'(1) == CW'(MAX_FAIL)) begin
              state_q <= S_LOCKOUT;
              timer_q <= LOCK_LOAD;
              alarm_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
`else
            state_q <= S_IDLE;
`endif
          end
        end
        S_OPEN: begin
          // Manual relock wins, then reprogramming, then hold-time expiry.
          if (key_clr) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else if (prog_req) begin
            state_q     <= S_PROG;
            timer_q     <= '0;
            unlock_q    <= 1'b0;
            prog_mode_q <= 1'b1;
          end else if (timer_q == '0) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_PROG: begin
          if (key_clr || key_ent) begin
            if (!key_clr && entry_cnt_q == CW'(DIGITS)) pw_q <= ent_buf_q;
            ent_buf_q   <= '0;
            entry_cnt_q <= '0;
            state_q     <= S_IDLE;
            prog_mode_q <= 1'b0;
          end else if (digit_ok) begin
            ent_buf_q[entry_cnt_q] <= key_digit;
            entry_cnt_q            <= entry_cnt_q + CW'(1);
          end
        end
`ifdef LOCKOUT_EN
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q    <= S_IDLE;
            alarm_q    <= 1'b0;
            fail_cnt_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          timer_q     <= '0;
          unlock_q    <= 1'b0;
          prog_mode_q <= 1'b0;
        end
      endcase
    end
  end

  assign unlock    = unlock_q;
  assign prog_mode = prog_mode_q;
  assign err       = err_q;
  assign entry_cnt = entry_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer; lockout expectations follow LOCKOUT_EN.
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_vld;
  logic [3:0] key_digit;
  logic       key_ent;
  logic       key_clr;
  logic       prog_req;
  logic       unlock;
  logic       alarm;
  logic       prog_mode;
  logic       err;
  logic [2:0] entry_cnt;
  logic [2:0] fail_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  lock_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .key_vld   (key_vld),
    .key_digit (key_digit),
    .key_ent   (key_ent),
    .key_clr   (key_clr),
    .prog_req  (prog_req),
    .unlock    (unlock),
    .alarm     (alarm),
    .prog_mode (prog_mode),
    .err       (err),
    .entry_cnt (entry_cnt),
    .fail_cnt  (fail_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    @(negedge clk);
    key_vld   = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_vld   = 1'b0;
  endtask

  task automatic press_ent();
    @(negedge clk);
    key_ent = 1'b1;
    @(negedge clk);
    key_ent = 1'b0;
  endtask

  task automatic press_clr();
    @(negedge clk);
    key_clr = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;
  endtask

  // Enter six digits (first digit in the top nibble), strobe enter, return at the outcome cycle.
  task automatic submit(input logic [23:0] code);
    for (int i = 0; i < 6; i++) press_digit(code[23-4*i -: 4]);
    press_ent();
    check("chk_state", int'(state), 2);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlock"}, int'(unlock), 0);
    check({tag, "_alarm"}, int'(alarm), 0);
    check({tag, "_prog"}, int'(prog_mode), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_cnt"}, int'(entry_cnt), 0);
    check({tag, "_fail"}, int'(fail_cnt), 0);
    check({tag, "_state"}, int'(state), 0);
  endtask

  initial begin
    int n;
    int pulses;
    clr = 1'b0; key_vld = 1'b0; key_digit = 4'd0; key_ent = 1'b0; key_clr = 1'b0; prog_req = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    clr = 1'b1;

    // Correct code: unlock two edges after enter, held for the full hold time.
    submit(24'h123456);
    check("open_unlock", int'(unlock), 1);
    check("open_state", int'(state), 3);
    check("open_err", int'(err), 0);
    check("open_fail", int'(fail_cnt), 0);
    n = 0;
    while (unlock && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("open_len", n, 500);
    check("open_exit_state", int'(state), 0);

    // Repeated mismatches.
    do_reset();
`ifdef LOCKOUT_EN
    for (int a = 1; a <= 2; a++) begin
      submit(24'h123457);
      check("mm_err", int'(err), 1);
      check("mm_fail", int'(fail_cnt), a);
      check("mm_state", int'(state), 0);
      @(negedge clk);
      check("mm_err_pulse", int'(err), 0);
    end
    submit(24'h123457);
    check("lk_err", int'(err), 1);
    check("lk_alarm", int'(alarm), 1);
    check("lk_state", int'(state), 5);
    check("lk_fail", int'(fail_cnt), 3);
    n = 0;
    while (alarm && n < 3000) begin
      key_digit = 4'd1;
      key_vld   = (n == 100);
      key_ent   = (n == 200);
      prog_req  = (n == 300);
      key_clr   = (n == 400);
      if (n == 150) check("lk_key_cnt", int'(entry_cnt), 0);
      if (n == 450) check("lk_key_state", int'(state), 5);
      n++;
      @(negedge clk);
    end
    key_vld = 1'b0; key_ent = 1'b0; prog_req = 1'b0; key_clr = 1'b0;
    check("lk_len", n, 1000);
    check("lk_exit_state", int'(state), 0);
    check("lk_exit_fail", int'(fail_cnt), 0);
    check("lk_exit_cnt", int'(entry_cnt), 0);

    // Reset in the middle of a lockout.
    for (int a = 0; a < 3; a++) submit(24'h111111);
    repeat (5) @(negedge clk);
    check("lk_mid_alarm", int'(alarm), 1);
    do_reset();
    check_all_zero("rst_lk");
`else
    pulses = 0;
    for (int a = 0; a < 5; a++) begin
      submit(24'h123457);
      pulses += int'(err);
      check("nl_alarm", int'(alarm), 0);
      check("nl_fail", int'(fail_cnt), 0);
      check("nl_state", int'(state), 0);
      @(negedge clk);
      check("nl_err_pulse", int'(err), 0);
    end
    check("nl_pulses", pulses, 5);
`endif

    // Reprogramming from OPEN.
    do_reset();
    submit(24'h123456);
    check("pg_open", int'(unlock), 1);
    @(negedge clk);
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
    check("pg_state", int'(state), 4);
    check("pg_mode", int'(prog_mode), 1);
    check("pg_unlock", int'(unlock), 0);
    for (int i = 0; i < 6; i++) press_digit(4'(9 - i));
    press_ent();
    check("pg_exit_state", int'(state), 0);
    check("pg_exit_mode", int'(prog_mode), 0);
    submit(24'h123456);
    check("pg_old_err", int'(err), 1);
    check("pg_old_unlock", int'(unlock), 0);
    submit(24'h987654);
    check("pg_new_unlock", int'(unlock), 1);
    check("pg_new_fail", int'(fail_cnt), 0);

    // Reset mid-OPEN restores the default password.
    repeat (10) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_all_zero("rst_open");
    clr = 1'b1;
    submit(24'h123456);
    check("rst_pw_unlock", int'(unlock), 1);
    press_clr();
    check("relock_unlock", int'(unlock), 0);
    check("relock_state", int'(state), 0);

    // Invalid digits, short enter, extra digits, clear priority.
    do_reset();
    press_digit(4'hA);
    check("inv_cnt", int'(entry_cnt), 0);
    check("inv_state", int'(state), 0);
    for (int i = 1; i <= 4; i++) press_digit(4'(i));
    press_digit(4'hF);
    check("inv2_cnt", int'(entry_cnt), 4);
    check("four_state", int'(state), 1);
    press_ent();
    check("short_state", int'(state), 0);
    check("short_cnt", int'(entry_cnt), 0);
    @(negedge clk);
    check("short_err", int'(err), 0);
    check("short_fail", int'(fail_cnt), 0);
    for (int i = 1; i <= 7; i++) press_digit(4'(i));
    check("sat_cnt", int'(entry_cnt), 6);
    check("sat_state", int'(state), 1);
    @(negedge clk);
    key_clr = 1'b1; key_vld = 1'b1; key_digit = 4'd1;
    @(negedge clk);
    key_clr = 1'b0; key_vld = 1'b0;
    check("clrwin_state", int'(state), 0);
    check("clrwin_cnt", int'(entry_cnt), 0);
    for (int i = 1; i <= 6; i++) press_digit(4'(i));
    press_digit(4'd9);
    press_ent();
    @(negedge clk);
    check("extra_ignored_unlock", int'(unlock), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
